// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, muldiv FSM states and the active_vec bit map
// used by the ALU result selector.
package alu_pkg;

    localparam logic [7:0] OP_MULU = 8'h30;
    localparam logic [7:0] OP_DIVU = 8'h32;
    localparam logic [7:0] OP_REMU = 8'h33;
    localparam logic [7:0] OP_MULS = 8'h34;
    localparam logic [7:0] OP_DIVS = 8'h36;
    localparam logic [7:0] OP_REMS = 8'h37;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    localparam int         ACT_ADD_BIT    = 0;
    localparam int         ACT_LOGIC_BIT  = 1;
    localparam int         ACT_SHIFT_BIT  = 2;
    localparam int         ACT_MULDIV_BIT = 3;
    localparam logic [3:0] ACT_MULDIV     = 4'b1000;

    function automatic logic op_is_mul(input logic [7:0] op);
        return (op == OP_MULU) || (op == OP_MULS);
    endfunction

    function automatic logic op_is_rem(input logic [7:0] op);
        return (op == OP_REMU) || (op == OP_REMS);
    endfunction

    function automatic logic op_is_signed(input logic [7:0] op);
        return (op == OP_MULS) || (op == OP_DIVS) || (op == OP_REMS);
    endfunction

    function automatic logic op_is_known(input logic [7:0] op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU) ||
               (op == OP_MULS) || (op == OP_DIVS) || (op == OP_REMS);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between dispatch and the multi-cycle mul/div unit.
interface alu_muldiv_if #(
    parameter int data_wl = 16,
    parameter int op_wl   = 8
) ();
    logic               start_in;
    logic [op_wl-1:0]   op_in;
    logic [data_wl-1:0] a_in;
    logic [data_wl-1:0] b_in;
    logic               busy_out;
    logic               valid_out;
    logic [data_wl-1:0] c_out;
    logic               z_flag_out;
    logic               s_flag_out;
    logic               c_flag_out;
    logic               ovr_flag_out;

    modport master (
        output start_in, op_in, a_in, b_in,
        input  busy_out, valid_out, c_out, z_flag_out, s_flag_out, c_flag_out, ovr_flag_out
    );

    modport slave (
        input  start_in, op_in, a_in, b_in,
        output busy_out, valid_out, c_out, z_flag_out, s_flag_out, c_flag_out, ovr_flag_out
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: right shift-add for multiply, left shift restoring
// subtract for divide. Purely combinational.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int data_wl = 16
) (
    input  step_mode_e         mode,
    input  logic [data_wl-1:0] acc,
    input  logic [data_wl-1:0] sreg,
    input  logic [data_wl-1:0] operand,
    output logic [data_wl-1:0] acc_nxt,
    output logic [data_wl-1:0] sreg_nxt
);
    logic [data_wl:0]   sum;
    logic [data_wl:0]   shifted;
    logic [data_wl-1:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (sreg[0] ? {1'b0, operand} : '0);
        shifted = {acc, sreg[data_wl-1]};
        // Partial remainder stays below the divisor, so the low bits of the difference are exact.
        diff    = shifted[data_wl-1:0] - operand;
        if (mode == STEP_MUL) begin
            acc_nxt  = sum[data_wl:1];
            sreg_nxt = {sum[0], sreg[data_wl-1:1]};
        end else if (shifted >= {1'b0, operand}) begin
            acc_nxt  = diff;
            sreg_nxt = {sreg[data_wl-2:0], 1'b1};
        end else begin
            acc_nxt  = shifted[data_wl-1:0];
            sreg_nxt = {sreg[data_wl-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// Sequential multiply/divide unit feeding the ALU MULDIV result path.
// ALU_MULDIV_SIGNED_EN enables MULS/DIVS/REMS; otherwise those opcodes are illegal.
//
// state | meaning
// IDLE  | waiting for start_in; latches op and operands
// RUN   | one radix-2 iteration per cycle, counter counts down
// DONE  | sign-correct and register result, pulse valid_out
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int data_wl = 16,
    parameter int op_wl   = 8
) (
    input logic         clk,
    input logic         rst_n,
    alu_muldiv_if.slave bus
);
    localparam int cnt_wl = $clog2(data_wl + 1);
    localparam logic [data_wl-1:0] most_neg = {1'b1, {(data_wl-1){1'b0}}};

    muldiv_state_e      state, state_nxt;
    logic [cnt_wl-1:0]  cnt;
    logic [op_wl-1:0]   op_reg;
    logic [data_wl-1:0] a_reg, b_reg, mag_b, acc, sreg;
    logic [data_wl-1:0] acc_nxt, sreg_nxt, mag_a_in, mag_b_in;
    logic               fast_in;
    step_mode_e         step_mode;

    logic [2*data_wl-1:0] prod;
    logic [data_wl-1:0]   quo, rem, res;
    logic                 res_c, res_ovr;

    function automatic logic op_legal(input logic [7:0] op);
`ifdef ALU_MULDIV_SIGNED_EN
        return op_is_known(op);
`else
        return op_is_known(op) && !op_is_signed(op);
`endif
    endfunction

`ifdef ALU_MULDIV_SIGNED_EN
    assign mag_a_in = (op_is_signed(bus.op_in) && bus.a_in[data_wl-1]) ? -bus.a_in : bus.a_in;
    assign mag_b_in = (op_is_signed(bus.op_in) && bus.b_in[data_wl-1]) ? -bus.b_in : bus.b_in;
`else
    assign mag_a_in = bus.a_in;
    assign mag_b_in = bus.b_in;
`endif

    assign fast_in   = !op_legal(bus.op_in) || (!op_is_mul(bus.op_in) && (bus.b_in == '0));
    assign step_mode = op_is_mul(op_reg) ? STEP_MUL : STEP_DIV;

    muldiv_step #(.data_wl(data_wl)) u_step (
        .mode     (step_mode),
        .acc      (acc),
        .sreg     (sreg),
        .operand  (mag_b),
        .acc_nxt  (acc_nxt),
        .sreg_nxt (sreg_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.busy_out = (state == RUN) || (state == DONE);
        case (state)
            IDLE:    if (bus.start_in) state_nxt = fast_in ? DONE : RUN;
            RUN:     if (cnt == cnt_wl'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result formation happens only in DONE, from magnitudes left by the iteration.
    always_comb begin
        prod    = {acc, sreg};
        quo     = sreg;
        rem     = acc;
        res     = '0;
        res_c   = 1'b0;
        res_ovr = 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
        if (op_is_signed(op_reg)) begin
            if (a_reg[data_wl-1] ^ b_reg[data_wl-1]) begin
                prod = -prod;
                quo  = -quo;
            end
            if (a_reg[data_wl-1]) rem = -rem;
        end
`endif
        if (!op_legal(op_reg)) begin
            res_ovr = 1'b1;
        end else if (op_is_mul(op_reg)) begin
            res     = prod[data_wl-1:0];
            res_ovr = op_is_signed(op_reg)
                    ? (prod[2*data_wl-1:data_wl] != {data_wl{prod[data_wl-1]}})
                    : (prod[2*data_wl-1:data_wl] != '0);
            res_c   = res_ovr;
        end else if (b_reg == '0) begin
            res     = op_is_rem(op_reg) ? a_reg : '1;
            res_ovr = 1'b1;
        end else if (op_is_rem(op_reg)) begin
            res = rem;
        end else begin
            res = quo;
`ifdef ALU_MULDIV_SIGNED_EN
            res_ovr = (op_reg == OP_DIVS) && (a_reg == most_neg) && (b_reg == '1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt              <= '0;
            op_reg           <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            mag_b            <= '0;
            acc              <= '0;
            sreg             <= '0;
            bus.valid_out    <= 1'b0;
            bus.c_out        <= '0;
            bus.z_flag_out   <= 1'b0;
            bus.s_flag_out   <= 1'b0;
            bus.c_flag_out   <= 1'b0;
            bus.ovr_flag_out <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            case (state)
                IDLE: if (bus.start_in) begin
                    op_reg <= bus.op_in;
                    a_reg  <= bus.a_in;
                    b_reg  <= bus.b_in;
                    mag_b  <= mag_b_in;
                    acc    <= '0;
                    sreg   <= mag_a_in;
                    cnt    <= cnt_wl'(data_wl);
                end
                RUN: begin
                    acc  <= acc_nxt;
                    sreg <= sreg_nxt;
                    cnt  <= cnt - 1'b1;
                end
                DONE: begin
                    bus.valid_out    <= 1'b1;
                    bus.c_out        <= res;
                    bus.z_flag_out   <= (res == '0);
                    bus.s_flag_out   <= res[data_wl-1];
                    bus.c_flag_out   <= res_c;
                    bus.ovr_flag_out <= res_ovr;
                end
                default: ;
            endcase
        end
    end
endmodule
